tlb_l2_ctrl: RTL and testbench

Sequencer between the L1 TLB miss path, the hash-rehash L2 TLB (`tlb_l2`) and the page-table walker. It accepts one L1 miss at a time and holds the lookup address on the L2 lookup port until the L2 reports that every hash has been checked. On an L2 hit it refills the L1. On an L2 miss it starts a walk, then writes the walk result into both the L2 and the L1. It also keeps saturating hit and miss counters.

---
 rtl/ariane_pkg.sv | 15 +
 rtl/riscv.sv | 20 ++
 rtl/tlb_l2_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_tlb_l2_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// TLB refill record shared by the L1 TLB, L2 TLB and page-table walker.
package ariane_pkg;

    localparam int unsigned ASID_WIDTH = 1;

    typedef struct packed {
        logic                  valid;
        logic                  is_2M;
        logic                  is_1G;
        logic [26:0]           vpn;
        logic [ASID_WIDTH-1:0] asid;
        riscv::pte_t           content;
    } tlb_update_t;

endpackage

// File: rtl/riscv.sv
// Minimal RISC-V definitions needed by the L2 TLB sequencer (Sv39 layout).
package riscv;

    localparam int unsigned VLEN = 39;

    typedef struct packed {
        logic [9:0]  reserved;
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

endpackage

// File: rtl/tlb_l2_ctrl.sv
// Sequencer between the L1 TLB miss path, the hash-rehash L2 TLB and the PTW.
// One miss in flight: L2 lookup, then L1 refill on hit or walk + L1/L2 refill on miss.
module tlb_l2_ctrl #(
    parameter int unsigned ASID_WIDTH  = 1,
    parameter int unsigned PTW_TIMEOUT = 256,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [ASID_WIDTH-1:0]    req_asid_i,
    input  logic [riscv::VLEN-1:0]   req_vaddr_i,
    output logic                     l2_access_o,
    output logic [ASID_WIDTH-1:0]    l2_asid_o,
    output logic [riscv::VLEN-1:0]   l2_vaddr_o,
    input  logic                     l2_hit_i,
    input  logic                     l2_is_2M_i,
    input  logic                     l2_is_1G_i,
    input  logic                     l2_all_checked_i,
    input  riscv::pte_t              l2_content_i,
    output ariane_pkg::tlb_update_t  l2_update_o,
    output ariane_pkg::tlb_update_t  l1_update_o,
    output logic                     ptw_req_o,
    output logic [ASID_WIDTH-1:0]    ptw_asid_o,
    output logic [riscv::VLEN-1:0]   ptw_vaddr_o,
    input  ariane_pkg::tlb_update_t  ptw_update_i,
    input  logic                     ptw_error_i,
    output logic                     resp_error_o,
    output logic [CNT_WIDTH-1:0]     hit_cnt_o,
    output logic [CNT_WIDTH-1:0]     miss_cnt_o
);

    localparam int unsigned TMO_W = (PTW_TIMEOUT > 1) ? $clog2(PTW_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        PTW_WAIT,
        REFILL,
        DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic [ASID_WIDTH-1:0]   asid_q, asid_d;
    logic [riscv::VLEN-1:0]  vaddr_q, vaddr_d;
    ariane_pkg::tlb_update_t upd_q, upd_d;
    logic                    src_ptw_q, src_ptw_d;
    logic                    err_q, err_d;
    logic                    flush_seen_q, flush_seen_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;

    assign l2_asid_o  = asid_q;
    assign l2_vaddr_o = vaddr_q;
    assign ptw_asid_o = asid_q;
    assign ptw_vaddr_o = vaddr_q;
    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

    // Next-state, request/response latching and state-decoded outputs
    always_comb begin
        state_d      = state_q;
        asid_d       = asid_q;
        vaddr_d      = vaddr_q;
        upd_d        = upd_q;
        src_ptw_d    = src_ptw_q;
        err_d        = err_q;
        flush_seen_d = flush_seen_q;
        tmo_d        = tmo_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        req_ready_o  = 1'b0;
        l2_access_o  = 1'b0;
        ptw_req_o    = 1'b0;
        resp_error_o = 1'b0;
        l1_update_o  = '0;
        l2_update_o  = '0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = !flush_i;
                if (req_valid_i && !flush_i) begin
                    asid_d       = req_asid_i;
                    vaddr_d      = req_vaddr_i;
                    flush_seen_d = 1'b0;
                    state_d      = LOOKUP;
                end
            end
            LOOKUP: begin
                l2_access_o = 1'b1;
                if (flush_i) flush_seen_d = 1'b1;
                // Exit only once every hash is checked so the L2 hash-order counter stays aligned
                if (l2_all_checked_i) begin
                    if (flush_i || flush_seen_q) begin
                        state_d = IDLE;
                    end else if (l2_hit_i) begin
                        upd_d         = '0;
                        upd_d.is_2M   = l2_is_2M_i;
                        upd_d.is_1G   = l2_is_1G_i;
                        upd_d.vpn     = vaddr_q[38:12];
                        upd_d.asid    = asid_q;
                        upd_d.content = l2_content_i;
                        src_ptw_d     = 1'b0;
                        err_d         = 1'b0;
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
                        state_d       = REFILL;
                    end else begin
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
                        tmo_d   = '0;
                        err_d   = 1'b0;
                        state_d = PTW_WAIT;
                    end
                end
            end
            PTW_WAIT: begin
                ptw_req_o = 1'b1;
                tmo_d     = tmo_q + TMO_W'(1);
                if (flush_i) begin
                    state_d = DRAIN;
                end else if (ptw_error_i) begin
                    err_d   = 1'b1;
                    state_d = REFILL;
                end else if (ptw_update_i.valid && (ptw_update_i.vpn == vaddr_q[38:12])) begin
                    upd_d       = ptw_update_i;
                    upd_d.valid = 1'b0;
                    src_ptw_d   = 1'b1;
                    state_d     = REFILL;
                end else if (tmo_q == TMO_W'(PTW_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = REFILL;
                end
            end
            DRAIN: begin
                if (ptw_update_i.valid || ptw_error_i) state_d = IDLE;
            end
            REFILL: begin
                state_d = IDLE;
                if (!flush_i) begin
                    if (err_q) begin
                        resp_error_o = 1'b1;
                    end else begin
                        l1_update_o       = upd_q;
                        l1_update_o.valid = 1'b1;
                        if (src_ptw_q) begin
                            l2_update_o       = upd_q;
                            l2_update_o.valid = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            asid_q       <= '0;
            vaddr_q      <= '0;
            upd_q        <= '0;
            src_ptw_q    <= 1'b0;
            err_q        <= 1'b0;
            flush_seen_q <= 1'b0;
            tmo_q        <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            asid_q       <= asid_d;
            vaddr_q      <= vaddr_d;
            upd_q        <= upd_d;
            src_ptw_q    <= src_ptw_d;
            err_q        <= err_d;
            flush_seen_q <= flush_seen_d;
            tmo_q        <= tmo_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_tlb_l2_ctrl.sv
// Directed testbench for tlb_l2_ctrl: L2 hit/miss paths, flushes, timeout, saturation, reset.
module tb_tlb_l2_ctrl;

    localparam int unsigned AW  = 1;
    localparam int unsigned TMO = 16;
    localparam int unsigned CW  = 2;

    logic                    clk_i = 1'b0;
    logic                    rst_ni = 1'b0;
    logic                    flush_i = 1'b0;
    logic                    req_valid_i = 1'b0;
    logic                    req_ready_o;
    logic [AW-1:0]           req_asid_i = '0;
    logic [riscv::VLEN-1:0]  req_vaddr_i = '0;
    logic                    l2_access_o;
    logic [AW-1:0]           l2_asid_o;
    logic [riscv::VLEN-1:0]  l2_vaddr_o;
    logic                    l2_hit_i = 1'b0;
    logic                    l2_is_2M_i = 1'b0;
    logic                    l2_is_1G_i = 1'b0;
    logic                    l2_all_checked_i = 1'b0;
    riscv::pte_t             l2_content_i = '0;
    ariane_pkg::tlb_update_t l2_update_o;
    ariane_pkg::tlb_update_t l1_update_o;
    logic                    ptw_req_o;
    logic [AW-1:0]           ptw_asid_o;
    logic [riscv::VLEN-1:0]  ptw_vaddr_o;
    ariane_pkg::tlb_update_t ptw_update_i = '0;
    logic                    ptw_error_i = 1'b0;
    logic                    resp_error_o;
    logic [CW-1:0]           hit_cnt_o;
    logic [CW-1:0]           miss_cnt_o;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] C1 = 64'h0012_3456_789A_BCCF;
    localparam logic [63:0] C2 = 64'h00AB_CDEF_0123_45DF;

    tlb_l2_ctrl #(.ASID_WIDTH(AW), .PTW_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_asid_i       (req_asid_i),
        .req_vaddr_i      (req_vaddr_i),
        .l2_access_o      (l2_access_o),
        .l2_asid_o        (l2_asid_o),
        .l2_vaddr_o       (l2_vaddr_o),
        .l2_hit_i         (l2_hit_i),
        .l2_is_2M_i       (l2_is_2M_i),
        .l2_is_1G_i       (l2_is_1G_i),
        .l2_all_checked_i (l2_all_checked_i),
        .l2_content_i     (l2_content_i),
        .l2_update_o      (l2_update_o),
        .l1_update_o      (l1_update_o),
        .ptw_req_o        (ptw_req_o),
        .ptw_asid_o       (ptw_asid_o),
        .ptw_vaddr_o      (ptw_vaddr_o),
        .ptw_update_i     (ptw_update_i),
        .ptw_error_i      (ptw_error_i),
        .resp_error_o     (resp_error_o),
        .hit_cnt_o        (hit_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request for one cycle, confirm it is accepted, advance to N+1
    task automatic accept(input logic [AW-1:0] asid, input logic [riscv::VLEN-1:0] va, input string tag);
        req_valid_i = 1'b1;
        req_asid_i  = asid;
        req_vaddr_i = va;
        #1;
        chk(tag, req_ready_o, 1'b1);
        tick();
        req_valid_i = 1'b0;
    endtask

    // Two unchecked hashes then a final checked miss (cycles N+1..N+3)
    task automatic l2_full_miss();
        l2_hit_i = 1'b0;
        l2_all_checked_i = 1'b0;
        tick();
        tick();
        l2_all_checked_i = 1'b1;
        tick();
        l2_all_checked_i = 1'b0;
    endtask

    // Hit on hash 0 at N+1, refill at N+2, idle at N+3
    task automatic hit_hash0(input logic [CW-1:0] exp_cnt, input string tag);
        accept(1'b0, 39'h00_0000_5000, tag);
        l2_hit_i = 1'b1;
        l2_all_checked_i = 1'b1;
        l2_content_i = C1;
        tick();
        l2_hit_i = 1'b0;
        l2_all_checked_i = 1'b0;
        l2_content_i = '0;
        #1;
        chk({tag, "_l1v"}, l1_update_o.valid, 1'b1);
        chk({tag, "_cnt"}, hit_cnt_o, exp_cnt);
        tick();
    endtask

    initial begin
        int preq_cycles;
        int err_pulses;
        int err_at;
        int l1v_seen;

        // Reset state
        tick();
        tick();
        chk("rst_ready", req_ready_o, 1'b1);
        chk("rst_access", l2_access_o, 1'b0);
        chk("rst_ptw_req", ptw_req_o, 1'b0);
        chk("rst_resp_err", resp_error_o, 1'b0);
        chk("rst_l1_upd", 64'(l1_update_o != '0), 64'd0);
        chk("rst_l2_upd", 64'(l2_update_o != '0), 64'd0);
        chk("rst_hit_cnt", hit_cnt_o, 0);
        chk("rst_miss_cnt", miss_cnt_o, 0);
        rst_ni = 1'b1;
        tick();

        // L2 hit at hash 0
        accept(1'b1, 39'h40_0000_1000, "t1_ready");
        l2_hit_i = 1'b1;
        l2_all_checked_i = 1'b1;
        l2_content_i = C1;
        #1;
        chk("t1_access", l2_access_o, 1'b1);
        chk("t1_l2_vaddr", l2_vaddr_o, 39'h40_0000_1000);
        chk("t1_l2_asid", l2_asid_o, 1'b1);
        chk("t1_busy", req_ready_o, 1'b0);
        tick();
        l2_hit_i = 1'b0;
        l2_all_checked_i = 1'b0;
        l2_content_i = '0;
        #1;
        chk("t1_l1_valid", l1_update_o.valid, 1'b1);
        chk("t1_l1_vpn", l1_update_o.vpn, 27'h4000001);
        chk("t1_l1_asid", l1_update_o.asid, 1'b1);
        chk("t1_l1_content", l1_update_o.content, C1);
        chk("t1_l2_valid", l2_update_o.valid, 1'b0);
        chk("t1_ptw_req", ptw_req_o, 1'b0);
        chk("t1_hit_cnt", hit_cnt_o, 1);
        tick();
        chk("t1_ready_again", req_ready_o, 1'b1);
        chk("t1_l1_pulse", l1_update_o.valid, 1'b0);

        // Full L2 miss, matching PTW update at N+8
        accept(1'b0, 39'h12_3456_7000, "t2_ready");
        l2_full_miss();
        chk("t2_ptw_req_n4", ptw_req_o, 1'b1);
        chk("t2_access_off", l2_access_o, 1'b0);
        chk("t2_miss_cnt", miss_cnt_o, 1);
        chk("t2_ptw_vaddr", ptw_vaddr_o, 39'h12_3456_7000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_ptw_req_hold", ptw_req_o, 1'b1);
        end
        tick();
        ptw_update_i = '0;
        ptw_update_i.valid = 1'b1;
        ptw_update_i.is_2M = 1'b1;
        ptw_update_i.vpn = 27'h1234567;
        ptw_update_i.content = C2;
        #1;
        chk("t2_ptw_req_n8", ptw_req_o, 1'b1);
        tick();
        ptw_update_i = '0;
        #1;
        chk("t2_l1_valid", l1_update_o.valid, 1'b1);
        chk("t2_l2_valid", l2_update_o.valid, 1'b1);
        chk("t2_l2_content", l2_update_o.content, C2);
        chk("t2_l1_2M", l1_update_o.is_2M, 1'b1);
        chk("t2_ptw_req_off", ptw_req_o, 1'b0);
        tick();
        chk("t2_valids_pulse", 64'({l1_update_o.valid, l2_update_o.valid}), 64'd0);
        chk("t2_ready_again", req_ready_o, 1'b1);

        // Flush at hash 1, hit reported at hash 2: result discarded
        accept(1'b1, 39'h00_0000_3000, "t3_ready");
        tick();
        flush_i = 1'b1;
        #1;
        chk("t3_access_h1", l2_access_o, 1'b1);
        tick();
        flush_i = 1'b0;
        l2_hit_i = 1'b1;
        l2_all_checked_i = 1'b1;
        l2_content_i = C1;
        #1;
        chk("t3_access_h2", l2_access_o, 1'b1);
        tick();
        l2_hit_i = 1'b0;
        l2_all_checked_i = 1'b0;
        l2_content_i = '0;
        #1;
        chk("t3_no_l1_valid", l1_update_o.valid, 1'b0);
        chk("t3_idle", req_ready_o, 1'b1);
        chk("t3_hit_cnt", hit_cnt_o, 1);

        // Flush in PTW_WAIT, PTW update 3 cycles later is drained
        accept(1'b0, 39'h00_0000_7000, "t4_ready");
        l2_full_miss();
        chk("t4_ptw_req", ptw_req_o, 1'b1);
        tick();
        flush_i = 1'b1;
        #1;
        chk("t4_ptw_req_flush", ptw_req_o, 1'b1);
        tick();
        flush_i = 1'b0;
        #1;
        chk("t4_drain_no_req", ptw_req_o, 1'b0);
        chk("t4_drain_busy", req_ready_o, 1'b0);
        tick();
        tick();
        ptw_update_i = '0;
        ptw_update_i.valid = 1'b1;
        ptw_update_i.vpn = 27'h7;
        #1;
        tick();
        ptw_update_i = '0;
        #1;
        chk("t4_no_valids", 64'({l1_update_o.valid, l2_update_o.valid}), 64'd0);
        chk("t4_idle", req_ready_o, 1'b1);
        chk("t4_miss_cnt", miss_cnt_o, 2);
        // Next request accepted, hit at hash 1
        accept(1'b1, 39'h00_0000_9000, "t4_next_ready");
        tick();
        l2_hit_i = 1'b1;
        l2_all_checked_i = 1'b1;
        l2_content_i = C2;
        tick();
        l2_hit_i = 1'b0;
        l2_all_checked_i = 1'b0;
        l2_content_i = '0;
        #1;
        chk("t4_next_l1_valid", l1_update_o.valid, 1'b1);
        chk("t4_next_vpn", l1_update_o.vpn, 27'h9);
        chk("t4_next_hit_cnt", hit_cnt_o, 2);
        tick();

        // PTW silent: timeout after TMO cycles in PTW_WAIT
        accept(1'b0, 39'h00_0000_B000, "t5_ready");
        l2_full_miss();
        preq_cycles = 0;
        err_pulses = 0;
        err_at = -1;
        l1v_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ptw_req_o) preq_cycles++;
            if (resp_error_o) begin
                err_pulses++;
                err_at = i;
            end
            if (l1_update_o.valid || l2_update_o.valid) l1v_seen++;
            tick();
        end
        chk("t5_ptw_req_cycles", preq_cycles, TMO);
        chk("t5_err_pulses", err_pulses, 1);
        chk("t5_err_cycle", err_at, TMO);
        chk("t5_no_valids", l1v_seen, 0);
        chk("t5_idle", req_ready_o, 1'b1);
        chk("t5_miss_cnt", miss_cnt_o, 3);

        // Mismatching vpn ignored, matching one accepted; miss counter saturated
        accept(1'b1, 39'h00_0000_D000, "t6_ready");
        l2_full_miss();
        chk("t6_miss_sat", miss_cnt_o, 3);
        ptw_update_i = '0;
        ptw_update_i.valid = 1'b1;
        ptw_update_i.vpn = 27'hE;
        #1;
        tick();
        ptw_update_i.vpn = 27'hD;
        ptw_update_i.content = C1;
        #1;
        chk("t6_still_waiting", ptw_req_o, 1'b1);
        chk("t6_no_l1_valid", l1_update_o.valid, 1'b0);
        tick();
        ptw_update_i = '0;
        #1;
        chk("t6_l1_valid", l1_update_o.valid, 1'b1);
        chk("t6_l2_vpn", l2_update_o.vpn, 27'hD);
        tick();

        // Hit counter saturation
        hit_hash0(2'd3, "t7_hit3");
        hit_hash0(2'd3, "t7_hit_sat");

        // Reset mid-PTW_WAIT
        accept(1'b0, 39'h00_0000_F000, "t8_ready");
        l2_full_miss();
        tick();
        chk("t8_in_ptw", ptw_req_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("t8_rst_ready", req_ready_o, 1'b1);
        chk("t8_rst_ptw_req", ptw_req_o, 1'b0);
        chk("t8_rst_access", l2_access_o, 1'b0);
        chk("t8_rst_hit_cnt", hit_cnt_o, 0);
        chk("t8_rst_miss_cnt", miss_cnt_o, 0);
        chk("t8_rst_vaddr", ptw_vaddr_o, 0);
        tick();
        ptw_update_i = '0;
        ptw_update_i.valid = 1'b1;
        ptw_update_i.vpn = 27'hF;
        rst_ni = 1'b1;
        #1;
        tick();
        ptw_update_i = '0;
        #1;
        chk("t8_walk_ignored", 64'({l1_update_o.valid, l2_update_o.valid}), 64'd0);
        chk("t8_idle", req_ready_o, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
